// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags
//   Synchronous FIFO of any depth (not only powers of two).
//   - Programmable almost_full / almost_empty thresholds.
//   - Live occupancy count.
//   - Optional first-word-fall-through (FWFT) read mode.
//   - Sticky overflow/underflow flags with an explicit clear.
//
// Parameters:
//   WIDTH      data word width (>= 1)
//   DEPTH      number of entries (>= 2, any integer)
//   FWFT       0 = registered read, 1 = first-word-fall-through
//   AF_THRESH  almost_full  when count >= AF_THRESH (1..DEPTH)
//   AE_THRESH  almost_empty when count <= AE_THRESH (0..DEPTH-1)
//
// Ports:
//   clk, rst                  clock; synchronous active-high reset
//   wr_en, wdata              write request and data
//   rd_en                     read / pop request
//   clr_err                   clears the sticky overflow/underflow flags
//   rdata, rvalid             read data and its qualifier
//   full, empty               count == DEPTH / count == 0
//   almost_full, almost_empty threshold flags
//   count                     current occupancy, 0..DEPTH
//   overflow, underflow       sticky error flags
module sync_fifo_flags #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int FWFT      = 0,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_en,
    input  logic             clr_err,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             rd_acc;
    logic             wr_acc;

    // Explicit wrap at DEPTH-1 so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty        = (count_q == '0);
    assign full         = (count_q == CW'(DEPTH));
    assign almost_full  = (count_q >= CW'(AF_THRESH));
    assign almost_empty = (count_q <= CW'(AE_THRESH));
    assign count        = count_q;

    assign rd_acc = rd_en && !empty;
    // A full FIFO still takes a write when a pop frees the slot in the same cycle.
    assign wr_acc = wr_en && (!full || rd_acc);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= ptr_next(wr_ptr);
            if (rd_acc) rd_ptr <= ptr_next(rd_ptr);
            if (wr_acc && !rd_acc)
                count_q <= count_q + CW'(1);
            else if (rd_acc && !wr_acc)
                count_q <= count_q - CW'(1);
            // A new error in the same cycle as clr_err wins.
            overflow  <= (overflow  && !clr_err) || (wr_en && !wr_acc);
            underflow <= (underflow && !clr_err) || (rd_en && !rd_acc);
        end
    end

    // Storage is not reset; reset only blocks the write.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) mem[wr_ptr] <= wdata;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented directly; forced to 0 while empty so the
            // output is clean after reset and never exposes stale entries.
            assign rdata  = empty ? '0 : mem[rd_ptr];
            assign rvalid = !empty;
        end else begin : g_std
            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata  <= '0;
                    rvalid <= 1'b0;
                end else begin
                    rvalid <= rd_acc;
                    if (rd_acc) rdata <= mem[rd_ptr];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Testbench for sync_fifo_flags: a registered-read and an FWFT instance
// (DEPTH=6, AF_THRESH=4, AE_THRESH=2) share one stimulus stream and are
// checked every cycle against a queue-based reference model.
module tb_sync_fifo_flags;

    localparam int W  = 8;
    localparam int D  = 6;
    localparam int AF = 4;
    localparam int AE = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         wr_en = 1'b0;
    logic [W-1:0] wdata = '0;
    logic         rd_en = 1'b0;
    logic         clr_err = 1'b0;

    logic [W-1:0] rdata_a, rdata_b;
    logic         rvalid_a, rvalid_b, full_a, full_b, empty_a, empty_b;
    logic         af_a, af_b, ae_a, ae_b, ovf_a, ovf_b, unf_a, unf_b;
    logic [2:0]   count_a, count_b;

    always #5 clk = ~clk;

    sync_fifo_flags #(.WIDTH(W), .DEPTH(D), .FWFT(0), .AF_THRESH(AF), .AE_THRESH(AE)) dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en), .clr_err(clr_err),
        .rdata(rdata_a), .rvalid(rvalid_a), .full(full_a), .empty(empty_a),
        .almost_full(af_a), .almost_empty(ae_a), .count(count_a),
        .overflow(ovf_a), .underflow(unf_a));

    sync_fifo_flags #(.WIDTH(W), .DEPTH(D), .FWFT(1), .AF_THRESH(AF), .AE_THRESH(AE)) dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en), .clr_err(clr_err),
        .rdata(rdata_b), .rvalid(rvalid_b), .full(full_b), .empty(empty_b),
        .almost_full(af_b), .almost_empty(ae_b), .count(count_b),
        .overflow(ovf_b), .underflow(unf_b));

    // Reference model
    logic [W-1:0] q[$];
    logic [W-1:0] m_rdata = '0;
    bit           m_rvalid = 0;
    bit           m_ovf = 0;
    bit           m_unf = 0;
    int           checks = 0;
    int           errors = 0;
    int           max_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int n = q.size();
        check("a_count", 32'(count_a), 32'(n));
        check("b_count", 32'(count_b), 32'(n));
        check("a_full",  32'(full_a),  32'(n == D));
        check("b_full",  32'(full_b),  32'(n == D));
        check("a_empty", 32'(empty_a), 32'(n == 0));
        check("b_empty", 32'(empty_b), 32'(n == 0));
        check("a_af",    32'(af_a),    32'(n >= AF));
        check("b_af",    32'(af_b),    32'(n >= AF));
        check("a_ae",    32'(ae_a),    32'(n <= AE));
        check("b_ae",    32'(ae_b),    32'(n <= AE));
        check("a_ovf",   32'(ovf_a),   32'(m_ovf));
        check("b_ovf",   32'(ovf_b),   32'(m_ovf));
        check("a_unf",   32'(unf_a),   32'(m_unf));
        check("b_unf",   32'(unf_b),   32'(m_unf));
        check("a_rvalid", 32'(rvalid_a), 32'(m_rvalid));
        check("a_rdata",  32'(rdata_a),  32'(m_rdata));
        check("b_rvalid", 32'(rvalid_b), 32'(n != 0));
        check("b_rdata",  32'(rdata_b),  (n != 0) ? 32'(q[0]) : 32'h0);
    endtask

    // One clock: drive on the falling edge, update model at the rising edge,
    // compare 1 time unit later.
    task automatic step(input bit w, input logic [W-1:0] d, input bit r,
                        input bit c, input bit rs = 0);
        bit racc, wacc;
        @(negedge clk);
        wr_en = w; wdata = d; rd_en = r; clr_err = c; rst = rs;
        @(posedge clk);
        if (rs) begin
            q.delete();
            m_rdata = '0; m_rvalid = 0; m_ovf = 0; m_unf = 0;
        end else begin
            racc = r && (q.size() > 0);
            wacc = w && ((q.size() < D) || racc);
            m_rvalid = racc;
            if (racc) m_rdata = q.pop_front();
            if (wacc) q.push_back(d);
            m_ovf = (m_ovf && !c) || (w && !wacc);
            m_unf = (m_unf && !c) || (r && !racc);
        end
        if (q.size() > max_cnt) max_cnt = q.size();
        #1;
        check_all();
    endtask

    initial begin
        // Reset
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);

        // Fill then drain
        for (int i = 1; i <= D; i++) step(1, W'(i), 0, 0);
        for (int i = 0; i < D; i++) step(0, 0, 1, 0);
        step(0, 0, 0, 0);

        // Interleaved pairs across pointer wrap
        max_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(1, W'(8'h10 + i), 0, 0);
            step(0, 0, 1, 0);
        end
        check("wrap_max_count", 32'(max_cnt <= 2), 32'h1);

        // Full boundary
        for (int i = 0; i < D; i++) step(1, W'(8'h60 + i), 0, 0);
        step(1, 8'hAA, 1, 0);
        step(1, 8'hBB, 0, 0);
        step(0, 0, 0, 1);
        for (int i = 0; i < D; i++) step(0, 0, 1, 0);
        check("aa_not_lost", 32'(rdata_a), 32'hAA);

        // Empty boundary
        step(1, 8'h55, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        step(0, 0, 0, 1);

        // FWFT presentation and pop
        step(1, 8'h3C, 0, 0);
        step(1, 8'h3D, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);

        // Reset mid-operation
        for (int i = 0; i < 4; i++) step(1, W'(8'h80 + i), 0, 0);
        step(1, 8'hEE, 1, 0, 1);
        step(1, 8'h77, 0, 0);
        step(0, 0, 1, 0);
        check("post_reset_data", 32'(rdata_a), 32'h77);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            int mode = (i / 100) % 3;   // vary write/read bias over phases
            bit w = (mode == 0) ? ($urandom_range(0, 3) != 0) :
                    (mode == 1) ? ($urandom_range(0, 3) == 0) : $urandom_range(0, 1) == 1;
            bit r = (mode == 1) ? ($urandom_range(0, 3) != 0) :
                    (mode == 0) ? ($urandom_range(0, 3) == 0) : $urandom_range(0, 1) == 1;
            bit c = ($urandom_range(0, 15) == 0);
            bit rs = ($urandom_range(0, 99) == 0);
            step(w, W'($urandom), r, c, rs);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
